// File: rtl/fma_ctrl.sv
// FMA issue/response controller: launches a fixed-latency FMA op, captures its flags and accrues fflags.
// Optional flush/kill support is enabled by defining FMA_CTRL_FLUSH_EN.
module fma_ctrl #(
  parameter int unsigned LAT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  output logic       fma_start,
  output logic [1:0] fma_op,
  input  logic [3:0] fma_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_flags,
  input  logic       flush,
  input  logic       csr_we,
  input  logic [4:0] csr_wdata,
  output logic [4:0] fflags,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [3:0] rsp_flags_q, rsp_flags_d;
  logic [4:0] fflags_q, fflags_d;
  logic       flush_i;
  logic       accept;
  logic       handshake;

`ifdef FMA_CTRL_FLUSH_EN
  assign flush_i = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_i      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rsp_flags_q <= '0;
      fflags_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rsp_flags_q <= rsp_flags_d;
      fflags_q    <= fflags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rsp_flags_d = rsp_flags_q;
    fflags_d    = fflags_q;

    req_ready = ((state_q == IDLE) || ((state_q == RESP) && rsp_ready)) && !flush_i;
    accept    = req_valid && req_ready;
    handshake = (state_q == RESP) && rsp_ready && !flush_i;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rsp_flags_d = fma_flags;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (flush_i)        state_d = IDLE;
        else if (rsp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d  = req_op;
      cnt_d = CNT_INIT;
    end

    // DZ has no FMA source; a CSR write in the same cycle overrides accrual.
    if (handshake) fflags_d = fflags_q | {rsp_flags_q[3], 1'b0, rsp_flags_q[2:0]};
    if (csr_we)    fflags_d = csr_wdata;
  end

  // The counter is only at its load value in the first EXEC cycle, including LAT=1.
  assign fma_start = (state_q == EXEC) && (cnt_q == CNT_INIT);
  assign fma_op    = op_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_flags = rsp_flags_q;
  assign fflags    = fflags_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fma_ctrl.sv
// Randomized scoreboard bench for fma_ctrl against a cycle-timestamp reference model.
module tb_fma_ctrl;
  localparam int unsigned LAT  = 4;
  localparam int          NCYC = 3000;
`ifdef FMA_CTRL_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic       fma_start;
  logic [1:0] fma_op;
  logic [3:0] fma_flags = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_flags;
  logic       flush = 1'b0;
  logic       csr_we = 1'b0;
  logic [4:0] csr_wdata = '0;
  logic [4:0] fflags;
  logic       busy;

  always #5 clk = ~clk;

  fma_ctrl #(.LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .fma_start(fma_start), .fma_op(fma_op), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_flags(rsp_flags),
    .flush(flush), .csr_we(csr_we), .csr_wdata(csr_wdata), .fflags(fflags), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [3:0] flags_arr [0:4095];
  logic [3:0] sb [$];

  // Reference model: an op accepted in cycle acc_cyc executes in cycles
  // acc_cyc+1 .. acc_cyc+LAT and responds from acc_cyc+LAT+1 until handshake.
  bit         busy_m = 1'b0;
  int         acc_cyc = 0;
  logic [4:0] ff_m = '0;
  logic [1:0] op_m = '0;

  bit         e_ready, e_valid, e_start, e_busy;
  logic [4:0] e_ff;
  logic [1:0] e_op;
  bit         in_rst = 1'b1;
  bit         done = 1'b0;
  bit         kill_pending = 1'b0;

  function automatic logic [4:0] acc_map(input logic [3:0] f);
    return {f[3], 1'b0, f[2:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each response handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst && !done) begin
        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_valid);
        check("fma_start", fma_start, e_start);
        check("busy", busy, e_busy);
        check("fflags", fflags, e_ff);
        if (e_busy) check("fma_op", fma_op, e_op);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_flags cycle %0d: got %0h expected none (scoreboard empty)", cyc, rsp_flags);
          end else begin
            check("rsp_flags", rsp_flags, sb[0]);
            if (rsp_ready && !(FLUSH_ON && flush)) void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Driver and reference model.
  initial begin
    bit fl, in_exec, in_resp, accept, hs, upd;
    logic [4:0] nff;
    int rst_todo;
    int next_rst;
    rst_todo = 2;
    next_rst = 900;
    foreach (flags_arr[i]) flags_arr[i] = 4'($urandom);

    #1;
    check("rst_fma_start", fma_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fflags", fflags, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_fma_op", fma_op, 0);
    check("rst_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    in_rst  = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      upd = 1'b0;
      if (kill_pending) begin
        void'(sb.pop_back());
        kill_pending = 1'b0;
      end
      in_exec = busy_m && (c <= acc_cyc + int'(LAT));
      in_resp = busy_m && (c > acc_cyc + int'(LAT));

      if (rst_todo > 0 && c >= next_rst && in_exec) begin
        rst_todo--;
        next_rst += 1000;
        in_rst    = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        csr_we    = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("arst_fma_start", fma_start, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_fflags", fflags, 0);
        check("arst_rsp_flags", rsp_flags, 0);
        check("arst_req_ready", req_ready, 1);
        #1 reset_n = 1'b1;
        busy_m = 1'b0;
        ff_m   = '0;
        sb.delete();
        in_rst = 1'b0;
      end else begin
        req_valid = ($urandom % 10) < 6;
        req_op    = 2'($urandom);
        rsp_ready = ($urandom % 10) < 7;
        flush     = ($urandom % 20) == 0;
        csr_we    = ($urandom % 16) == 0;
        csr_wdata = 5'($urandom);
        fma_flags = flags_arr[c];

        fl      = FLUSH_ON && flush;
        e_start = busy_m && (c == acc_cyc + 1);
        e_valid = in_resp;
        e_busy  = busy_m;
        e_ready = (!busy_m || (in_resp && rsp_ready)) && !fl;
        e_ff    = ff_m;
        e_op    = op_m;

        accept = req_valid && e_ready;
        hs     = in_resp && rsp_ready && !fl;
        nff    = ff_m;
        if (hs) nff = ff_m | acc_map(flags_arr[acc_cyc + int'(LAT)]);
        if (csr_we) nff = csr_wdata;
        if (accept) sb.push_back(flags_arr[c + int'(LAT)]);
        if (fl && busy_m) kill_pending = 1'b1;
        upd = 1'b1;
      end

      @(posedge clk);
      if (upd) begin
        ff_m = nff;
        if (accept) begin
          busy_m  = 1'b1;
          acc_cyc = c;
          op_m    = req_op;
        end else if (hs || (fl && busy_m)) begin
          busy_m = 1'b0;
        end
      end
      @(negedge clk);
    end

    done = 1'b1;
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fma_ctrl.md
FMA_CTRL -- requirements
Module: fma_ctrl

Interface
REQ-001 Parameter LAT, default 4, FMA datapath latency in cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  issue stage presents an FMA op.
REQ-005 req_ready  output  1  controller accepts op this cycle.
REQ-006 req_op  input  2  00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd.
REQ-007 fma_start  output  1  one-cycle launch pulse to FMA datapath.
REQ-008 fma_op  output  2  registered op, held stable from launch until return to IDLE.
REQ-009 fma_flags  input  4  {invalid, overflow, underflow, inexact} from FMA flag logic; meaningful only in final EXEC cycle.
REQ-010 rsp_valid  output  1  result and flags available to writeback.
REQ-011 rsp_ready  input  1  writeback accepts response.
REQ-012 rsp_flags  output  4  flags captured for current op, same order as fma_flags.
REQ-013 flush  input  1  kill in-flight op (trap or branch mispredict).
REQ-014 csr_we  input  1  CSR write to fflags.
REQ-015 csr_wdata  input  5  new fflags value {NV,DZ,OF,UF,NX}.
REQ-016 fflags  output  5  sticky accrued exception flags {NV,DZ,OF,UF,NX}.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, EXEC, RESP; encoding left to implementer.
REQ-019 req_ready = (state==IDLE or (state==RESP and rsp_ready)) and not flush; the combinational path rsp_ready->req_ready is intentional.
REQ-020 On req_valid and req_ready: latch req_op into fma_op, load cnt=LAT-1, enter EXEC.
REQ-021 fma_start is high for exactly the first EXEC cycle of each op, otherwise low.
REQ-022 In EXEC with cnt!=0: decrement cnt; with cnt==0: capture fma_flags into rsp_flags, enter RESP.
REQ-023 Latency: op accepted in cycle t gives rsp_valid first high in cycle t+LAT+1.
REQ-024 rsp_valid is high exactly in RESP; rsp_flags is held stable while rsp_valid and not rsp_ready.
REQ-025 On rsp_valid and rsp_ready: fflags <= fflags | {rsp_flags[3],1'b0,rsp_flags[2:0]}; next state is EXEC if a new op is accepted in the same cycle, else IDLE.
REQ-026 DZ (fflags[3]) is never set by FMA accumulation; only csr_we can change it.
REQ-027 csr_we in the same cycle as accumulation: fflags <= csr_wdata; the accumulation is discarded.
REQ-028 flush in EXEC or RESP: next state IDLE, no fflags update, rsp_valid low next cycle, fma_start never reasserted for the killed op.
REQ-029 flush has priority over rsp_ready and req_valid in the same cycle.
REQ-030 flush in IDLE: no effect other than forcing req_ready low.
REQ-031 With LAT=1, EXEC lasts one cycle, and fma_start and the flag capture occur in that same cycle.

Reset
REQ-032 While reset_n is low: state=IDLE, cnt=0, fma_op=0, rsp_flags=0, fflags=0; outputs fma_start=0, rsp_valid=0, busy=0.
REQ-033 Reset asserted mid-operation abandons the op with no fflags update; the first cycle after deassertion behaves as IDLE.

Configuration
REQ-034 Macro FMA_CTRL_FLUSH_EN: when defined, flush behaves per REQ-028..REQ-030.
REQ-035 When FMA_CTRL_FLUSH_EN is undefined, the flush input is ignored (treated as 0) and every accepted op runs to RESP.

Verification
REQ-036 LAT=4, accept fmadd in cycle 0, fma_flags=4'b0001 in cycle 4, rsp_ready=1 -> fma_start high in cycle 1 only, rsp_valid high in cycle 5, fflags=5'b00001 in cycle 6.
REQ-037 Two ops with flags 4'b1000 and 4'b0011, second accepted in the same cycle as the first response -> fflags=5'b10011; the second fma_start follows with no idle cycle.
REQ-038 rsp_ready held low 3 cycles in RESP while fma_flags toggles -> rsp_flags and rsp_valid stable; fflags unchanged until handshake.
REQ-039 flush in cycle 2 of EXEC (FMA_CTRL_FLUSH_EN defined) -> state IDLE in cycle 3, rsp_valid never high, fflags unchanged; same stimulus without the macro -> normal response.
REQ-040 csr_we=1, csr_wdata=5'b01000 in the same cycle as a handshake with rsp_flags=4'b0001 -> fflags=5'b01000.
REQ-041 reset_n pulsed low mid-EXEC with fflags=5'b10101 -> all outputs 0 immediately (asynchronously), fflags=0, req_ready=1 after release.
